// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, error codes, FSM states and op decode helpers for mem_lsu
package lsu_pkg;

   localparam logic [3:0] OP_LB  = 4'h0;
   localparam logic [3:0] OP_LH  = 4'h1;
   localparam logic [3:0] OP_LW  = 4'h2;
   localparam logic [3:0] OP_LD  = 4'h3;
   localparam logic [3:0] OP_LBU = 4'h4;
   localparam logic [3:0] OP_LHU = 4'h5;
   localparam logic [3:0] OP_SB  = 4'h8;
   localparam logic [3:0] OP_SH  = 4'h9;
   localparam logic [3:0] OP_SW  = 4'hA;
   localparam logic [3:0] OP_SD  = 4'hB;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } lsu_err_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
`ifdef MEM_LSU_SPLIT_EN
      ACCESS2 = 2'd3,
`endif
      RESP    = 2'd2
   } lsu_state_e;

   function automatic logic op_is_known(input logic [3:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU,
                        OP_SB, OP_SH, OP_SW, OP_SD};
   endfunction

   function automatic logic [1:0] op_size(input logic [3:0] op);
      if (op inside {OP_LB, OP_LBU, OP_SB}) return SZ_B;
      if (op inside {OP_LH, OP_LHU, OP_SH}) return SZ_H;
      if (op inside {OP_LW, OP_SW})         return SZ_W;
      return SZ_D;
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
   endfunction

   function automatic logic op_is_unsigned(input logic [3:0] op);
      return op inside {OP_LBU, OP_LHU};
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane enables, store lane replication and load extension
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]                  size_i,
   input  logic                        uns_i,
   input  logic [$clog2(DATA_W/8)-1:0] off_i,
   input  logic [DATA_W-1:0]           wdata_i,
   input  logic [DATA_W-1:0]           rdata_lo_i,
   input  logic [DATA_W-1:0]           rdata_hi_i,
   output logic [DATA_W/8-1:0]         byteen_lo_o,
   output logic [DATA_W/8-1:0]         byteen_hi_o,
   output logic [DATA_W-1:0]           wdata_o,
   output logic [DATA_W-1:0]           ldata_o
);
   localparam int NB = DATA_W / 8;

   logic [NB-1:0]     sz_mask;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] rd_sh;
   logic [2*NB-1:0]   be_wide;
   logic              sign;
   int                ext_from;

   always_comb begin
      sz_mask = '1;
      pat     = wdata_i;
      case (size_i)
         SZ_B:    begin sz_mask = NB'(1);  pat = {NB{wdata_i[7:0]}};        end
         SZ_H:    begin sz_mask = NB'(3);  pat = {(NB/2){wdata_i[15:0]}};   end
         SZ_W:    begin sz_mask = NB'(15); pat = {(NB/4){wdata_i[31:0]}};   end
         default: ;
      endcase
   end

   // Lanes that spill past the bus edge land in the next word's low lanes.
   assign be_wide     = {{NB{1'b0}}, sz_mask} << off_i;
   assign byteen_lo_o = be_wide[NB-1:0];
   assign byteen_hi_o = be_wide[2*NB-1:NB];

   // Rotating the replicated pattern serves both halves of a split store.
   assign wdata_o = DATA_W'({pat, pat} >> (DATA_W - 8 * int'(off_i)));
   assign rd_sh   = DATA_W'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

   always_comb begin
      ext_from = DATA_W;
      sign     = 1'b0;
      case (size_i)
         SZ_B:    begin ext_from = 8;  sign = rd_sh[7];  end
         SZ_H:    begin ext_from = 16; sign = rd_sh[15]; end
         SZ_W:    begin ext_from = 32; sign = rd_sh[31]; end
         default: ;
      endcase
      ldata_o = rd_sh;
      for (int b = 0; b < DATA_W; b++)
         if (b >= ext_from) ldata_o[b] = sign & ~uns_i;
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-outstanding load/store unit with lane alignment and ack timeout
// MEM_LSU_SPLIT_EN: split bus-crossing misaligned accesses into two aligned ones.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_byteen,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_err
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   lsu_state_e        state_q, state_d;
   lsu_err_e          err_q, err_d;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [1:0]        size;
   logic              is_store;
   logic              phase2;
   logic [OFF_W-1:0]  off;
   logic [ADDR_W-1:0] base_addr;
   logic [NB-1:0]     be_lo, be_hi;
   logic [DATA_W-1:0] al_wdata, ld_data, rd_lo;

   function automatic logic req_legal(input logic [3:0] op);
      return op_is_known(op) && (DATA_W == 64 || op_size(op) != SZ_D);
   endfunction

   function automatic logic req_misal(input logic [3:0] op, input logic [OFF_W-1:0] o);
      return (o & OFF_W'((32'd1 << op_size(op)) - 32'd1)) != '0;
   endfunction

   assign size      = op_size(op_q);
   assign is_store  = op_is_store(op_q);
   assign off       = addr_q[OFF_W-1:0];
   assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_LSU_SPLIT_EN
   logic [DATA_W-1:0] rlo_q, rlo_d;
   logic              crosses;
   assign phase2  = (state_q == ACCESS2);
   assign rd_lo   = phase2 ? rlo_q : mem_rdata;
   assign crosses = (32'(off) + (32'd1 << size)) > 32'(NB);
`else
   assign phase2  = 1'b0;
   assign rd_lo   = mem_rdata;
`endif

   lsu_lane_align #(.DATA_W(DATA_W)) u_align (
      .size_i      (size),
      .uns_i       (op_is_unsigned(op_q)),
      .off_i       (off),
      .wdata_i     (wdata_q),
      .rdata_lo_i  (rd_lo),
      .rdata_hi_i  (mem_rdata),
      .byteen_lo_o (be_lo),
      .byteen_hi_o (be_hi),
      .wdata_o     (al_wdata),
      .ldata_o     (ld_data)
   );

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
`ifdef MEM_LSU_SPLIT_EN
      rlo_d     = rlo_q;
`endif
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = ERR_OK;
               state_d = ACCESS;
               if (!req_legal(req_op)) begin
                  err_d   = ERR_ILLEGAL;
                  state_d = RESP;
               end
`ifndef MEM_LSU_SPLIT_EN
               else if (req_misal(req_op, req_addr[OFF_W-1:0])) begin
                  err_d   = ERR_MISALIGN;
                  state_d = RESP;
               end
`endif
            end
         end
         ACCESS: begin
            // An ack in the final counted cycle still wins over the timeout.
            if (mem_ack) begin
               cnt_d   = '0;
               state_d = RESP;
               if (!is_store) rdata_d = ld_data;
`ifdef MEM_LSU_SPLIT_EN
               if (crosses) begin
                  rlo_d   = mem_rdata;
                  rdata_d = rdata_q;
                  state_d = ACCESS2;
               end
`endif
            end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`ifdef MEM_LSU_SPLIT_EN
         ACCESS2: begin
            if (mem_ack) begin
               state_d = RESP;
               if (!is_store) rdata_d = ld_data;
            end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         err_q   <= ERR_OK;
         rdata_q <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MEM_LSU_SPLIT_EN
         rlo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
`ifdef MEM_LSU_SPLIT_EN
         rlo_q   <= rlo_d;
`endif
         if (req_valid && req_ready) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   // Outputs decode straight from state so an asynchronous reset clears them at once.
`ifdef MEM_LSU_SPLIT_EN
   assign mem_req = (state_q == ACCESS) || (state_q == ACCESS2);
`else
   assign mem_req = (state_q == ACCESS);
`endif
   assign mem_we     = mem_req && is_store;
   assign mem_addr   = !mem_req ? '0 : (phase2 ? base_addr + ADDR_W'(NB) : base_addr);
   assign mem_byteen = !mem_req ? '0 : (phase2 ? be_hi : be_lo);
   assign mem_wdata  = mem_we ? al_wdata : '0;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_rdata  = rsp_valid ? rdata_q : '0;
   assign rsp_err    = rsp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed table-driven bench for mem_lsu (DATA_W=32, TIMEOUT_CYC=4)
module tb_mem_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byteen;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_byteen (mem_byteen),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      int          exp_mreq;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{be[i]}};
   endfunction

   task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input string tag);
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_op = 4'h0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int    mreq_n  = 0;
      int    rsp_cyc = -1;
      string tag     = $sformatf("v%0d", idx);
      present(v.op, v.addr, v.wdata, tag);
      for (int cyc = 0; cyc < 40 && rsp_cyc < 0; cyc++) begin
         mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
         if (mem_req) begin
            chk({tag, "_addr"}, mem_addr, v.exp_addr);
            chk({tag, "_be"}, mem_byteen, v.exp_be);
            chk({tag, "_we"}, mem_we, v.exp_we);
            chk({tag, "_busy"}, req_ready, 1'b0);
            if (v.exp_we)
               chk({tag, "_wdata"}, mem_wdata & lane_mask(v.exp_be), v.exp_wdata);
            if (mreq_n == v.ack_at) begin mem_ack = 1'b1; mem_rdata = v.rdata; end
            mreq_n++;
         end
         if (rsp_valid) begin
            rsp_cyc = cyc;
            chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
            chk({tag, "_err"}, rsp_err, v.exp_err);
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk({tag, "_rsp_cycle"}, rsp_cyc, v.exp_mreq);
      chk({tag, "_mreq_cycles"}, mreq_n, v.exp_mreq);
      chk({tag, "_pulse"}, rsp_valid, 1'b0);
   endtask

   task automatic run_split(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                            input logic [31:0] a2, input logic [3:0] be2, input logic [31:0] wd2,
                            input logic [31:0] exp_rd);
      int mreq_n  = 0;
      int rsp_cyc = -1;
      present(op, addr, wd, tag);
      for (int cyc = 0; cyc < 40 && rsp_cyc < 0; cyc++) begin
         mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
         if (mem_req) begin
            chk({tag, "_addr"}, mem_addr, (mreq_n == 0) ? a1 : a2);
            chk({tag, "_be"}, mem_byteen, (mreq_n == 0) ? be1 : be2);
            if (op_is_store(op))
               chk({tag, "_wdata"}, mem_wdata & lane_mask(mem_byteen), (mreq_n == 0) ? wd1 : wd2);
            mem_ack = 1'b1; mem_rdata = (mreq_n == 0) ? rd1 : rd2;
            mreq_n++;
         end
         if (rsp_valid) begin
            rsp_cyc = cyc;
            chk({tag, "_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "_err"}, rsp_err, 2'b00);
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk({tag, "_mreq_cycles"}, mreq_n, 2);
      chk({tag, "_rsp_cycle"}, rsp_cyc, 2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;

      //        op      addr          wdata         rdata         ack we addr          be     exp_wdata     exp_rdata     err    mreq
      vt.push_back('{OP_SW,  32'h1000, 32'hDEADBEEF, 32'h0,        2,  1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0,        2'b00, 3});
      vt.push_back('{OP_LB,  32'h2003, 32'h0,        32'h80FFFFFF, 0,  0, 32'h2000, 4'h8, 32'h0,        32'hFFFFFF80, 2'b00, 1});
      vt.push_back('{OP_LBU, 32'h2003, 32'h0,        32'h80FFFFFF, 1,  0, 32'h2000, 4'h8, 32'h0,        32'h00000080, 2'b00, 2});
      vt.push_back('{OP_SH,  32'h3002, 32'h0000ABCD, 32'h0,        0,  1, 32'h3000, 4'hC, 32'hABCD0000, 32'h0,        2'b00, 1});
      vt.push_back('{OP_LH,  32'h3002, 32'h0,        32'h80011234, 0,  0, 32'h3000, 4'hC, 32'h0,        32'hFFFF8001, 2'b00, 1});
      vt.push_back('{OP_LHU, 32'h3000, 32'h0,        32'h8001F234, 0,  0, 32'h3000, 4'h3, 32'h0,        32'h0000F234, 2'b00, 1});
      vt.push_back('{OP_LW,  32'h5004, 32'h0,        32'h12345678, 0,  0, 32'h5004, 4'hF, 32'h0,        32'h12345678, 2'b00, 1});
      vt.push_back('{OP_SB,  32'h6001, 32'h000000A5, 32'h0,        0,  1, 32'h6000, 4'h2, 32'h0000A500, 32'h0,        2'b00, 1});
      vt.push_back('{OP_LW,  32'h7000, 32'h0,        32'h0,        255,0, 32'h7000, 4'hF, 32'h0,        32'h0,        2'b10, 4});
      vt.push_back('{OP_LW,  32'h7100, 32'h0,        32'hCAFEF00D, 3,  0, 32'h7100, 4'hF, 32'h0,        32'hCAFEF00D, 2'b00, 4});
      vt.push_back('{OP_LD,  32'h8000, 32'h0,        32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b11, 0});
      vt.push_back('{OP_SD,  32'h8000, 32'h11111111, 32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b11, 0});
      vt.push_back('{4'hF,   32'h8000, 32'h0,        32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b11, 0});
`ifdef MEM_LSU_SPLIT_EN
      vt.push_back('{OP_LH,  32'h3001, 32'h0,        32'h00ABCD00, 0,  0, 32'h3000, 4'h6, 32'h0,        32'hFFFFABCD, 2'b00, 1});
`else
      vt.push_back('{OP_LH,  32'h3001, 32'h0,        32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b01, 0});
      vt.push_back('{OP_LW,  32'h4001, 32'h0,        32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b01, 0});
      vt.push_back('{OP_SW,  32'h1002, 32'h12345678, 32'h0,        0,  0, 32'h0,    4'h0, 32'h0,        32'h0,        2'b01, 0});
`endif

      repeat (3) @(negedge clk);
      chk("rst_low_ready", req_ready, 1'b1);
      chk("rst_low_mreq", mem_req, 1'b0);
      chk("rst_low_rsp", rsp_valid, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_mreq", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_be", mem_byteen, 4'h0);
      chk("rst_rsp", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", rsp_err, 2'b00);

      foreach (vt[i]) run_vec(i, vt[i]);

`ifdef MEM_LSU_SPLIT_EN
      run_split("split_lw", OP_LW, 32'h4001, 32'h0, 32'h332211AA, 32'hDDCCBB44,
                32'h4000, 4'hE, 32'h0, 32'h4004, 4'h1, 32'h0, 32'h44332211);
      run_split("split_wrap_sh", OP_SH, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 32'h0,
                32'hFFFFFFFC, 4'h8, 32'hEF000000, 32'h0, 4'h1, 32'h000000BE, 32'h0);
`endif

      // Acks while idle must not start anything.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
         @(negedge clk);
         chk("stray_ack_mreq", mem_req, 1'b0);
         chk("stray_ack_rsp", rsp_valid, 1'b0);
      end
      mem_ack = 1'b0;

      // Reset in the middle of an access.
      present(OP_LW, 32'h9000, 32'h0, "rst_mid");
      chk("rst_mid_mreq0", mem_req, 1'b1);
      @(negedge clk);
      chk("rst_mid_mreq1", mem_req, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_mreq", mem_req, 1'b0);
      chk("rst_mid_ready", req_ready, 1'b1);
      chk("rst_mid_rsp", rsp_valid, 1'b0);
      chk("rst_mid_be", mem_byteen, 4'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_after_rsp", rsp_valid, 1'b0);
         chk("rst_after_mreq", mem_req, 1'b0);
      end
      run_vec(100, vt[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
